// File: rtl/ldq_branch_filter_pkg.sv
// Shared load-queue epoch definitions.
// BRANCH_ID_WIDTH : width of the epoch (branch id) carried in the memory sideband.
// BRANCH_ID_LSB/MSB : sideband bit positions of the epoch field. Request stamping
//                     and ack extraction both use these positions.
package toy_pack;

  localparam int unsigned BRANCH_ID_LSB   = 7;
  localparam int unsigned BRANCH_ID_MSB   = 9;
  localparam int unsigned BRANCH_ID_WIDTH = BRANCH_ID_MSB - BRANCH_ID_LSB + 1;

endpackage : toy_pack

// File: rtl/ldq_branch_filter.sv
// Epoch tracker and stale-response filter for the LSU load queue.
// The epoch advances on every cancel edge. The live (next) epoch is handed to
// request stamping, and memory acks whose epoch differs from it are dropped.
//
// Ports:
//   clk                : clock, rising edge
//   rst_n              : asynchronous reset, active-high (historical name)
//   mem_ack_vld        : raw memory ack valid
//   mem_ack_branch_id  : epoch returned in the ack sideband
//   cancel_edge_en     : one-cycle pulse at the start of a flush/cancel
//   req_branch_id_nxt  : epoch to stamp into requests issued this cycle
//   branch_ack_vld     : ack valid forwarded to the load queue
//   stale_ack_vld      : pulses when an ack is dropped as stale
module ldq_branch_filter
  import toy_pack::*;
#(
  parameter int unsigned ID_WIDTH = BRANCH_ID_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                mem_ack_vld,
  input  logic [ID_WIDTH-1:0] mem_ack_branch_id,
  input  logic                cancel_edge_en,
  output logic [ID_WIDTH-1:0] req_branch_id_nxt,
  output logic                branch_ack_vld,
  output logic                stale_ack_vld
);

  logic [ID_WIDTH-1:0] branch_id;
  logic [ID_WIDTH-1:0] epoch_live;
  logic                id_match;

  // The live epoch already includes a cancel in this cycle, so post-flush
  // requests and acks are judged against the new epoch. Wraps modulo 2^ID_WIDTH.
  always_comb begin
    epoch_live = branch_id;
    if (cancel_edge_en) begin
      epoch_live = branch_id + ID_WIDTH'(1);
    end
  end

  // Epoch register
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      branch_id <= '0;
    end else begin
      branch_id <= epoch_live;
    end
  end

  // Zero-latency filter. While reset is asserted, outputs are forced quiet even
  // if a cancel or ack arrives. Only valid is masked; the bus still consumes the ack.
  always_comb begin
    id_match          = (mem_ack_branch_id == epoch_live);
    req_branch_id_nxt = epoch_live;
    branch_ack_vld    = mem_ack_vld & id_match;
    stale_ack_vld     = mem_ack_vld & ~id_match;
    if (rst_n) begin
      req_branch_id_nxt = '0;
      branch_ack_vld    = 1'b0;
      stale_ack_vld     = 1'b0;
    end
  end

endmodule : ldq_branch_filter

// File: tb/tb_ldq_branch_filter.sv
// Directed bench for ldq_branch_filter: reset, single cancel, wrap,
// back-to-back cancels, mid-stream reset and cycles with no ack.
module tb_ldq_branch_filter;

  logic       clk;
  logic       rst_n;
  logic       mem_ack_vld;
  logic [2:0] mem_ack_branch_id;
  logic       cancel_edge_en;
  logic [2:0] req_branch_id_nxt;
  logic       branch_ack_vld;
  logic       stale_ack_vld;

  int total;
  int bad;

  ldq_branch_filter dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .mem_ack_vld       (mem_ack_vld),
    .mem_ack_branch_id (mem_ack_branch_id),
    .cancel_edge_en    (cancel_edge_en),
    .req_branch_id_nxt (req_branch_id_nxt),
    .branch_ack_vld    (branch_ack_vld),
    .stale_ack_vld     (stale_ack_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and move 1 time unit past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic cancel, input logic vld, input logic [2:0] id);
    cancel_edge_en    = cancel;
    mem_ack_vld       = vld;
    mem_ack_branch_id = id;
    #2;
  endtask

  task automatic test_reset();
    // Reset is asserted from time 0. A cancel and an ack during reset must stay invisible.
    drive(1'b1, 1'b1, 3'd0);
    tick();
    drive(1'b1, 1'b1, 3'd0);
    total++;
    if ({req_branch_id_nxt, branch_ack_vld, stale_ack_vld} !== {3'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_hold: got nxt=%0d ack=%0b stale=%0b, want nxt=0 ack=0 stale=0",
               req_branch_id_nxt, branch_ack_vld, stale_ack_vld);
    end
    tick();
    rst_n = 1'b0;
    drive(1'b0, 1'b1, 3'd0);
    total++;
    if ({req_branch_id_nxt, branch_ack_vld, stale_ack_vld} !== {3'd0, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL reset_idle_ack0: got nxt=%0d ack=%0b stale=%0b, want nxt=0 ack=1 stale=0",
               req_branch_id_nxt, branch_ack_vld, stale_ack_vld);
    end
    tick();
  endtask

  task automatic test_single_cancel();
    // Epoch is 0. An ack with the old id in the cancel cycle is stale.
    drive(1'b1, 1'b1, 3'd0);
    total++;
    if ({req_branch_id_nxt, branch_ack_vld, stale_ack_vld} !== {3'd1, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL cancel_T_old: got nxt=%0d ack=%0b stale=%0b, want nxt=1 ack=0 stale=1",
               req_branch_id_nxt, branch_ack_vld, stale_ack_vld);
    end
    tick();
    drive(1'b0, 1'b1, 3'd0);
    total++;
    if ({req_branch_id_nxt, branch_ack_vld, stale_ack_vld} !== {3'd1, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL cancel_T1_old: got nxt=%0d ack=%0b stale=%0b, want nxt=1 ack=0 stale=1",
               req_branch_id_nxt, branch_ack_vld, stale_ack_vld);
    end
    drive(1'b0, 1'b1, 3'd1);
    total++;
    if ({req_branch_id_nxt, branch_ack_vld, stale_ack_vld} !== {3'd1, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL cancel_T1_new: got nxt=%0d ack=%0b stale=%0b, want nxt=1 ack=1 stale=0",
               req_branch_id_nxt, branch_ack_vld, stale_ack_vld);
    end
    tick();
  endtask

  task automatic test_wrap();
    logic [2:0] exp_id;
    // A short asynchronous reset pulse returns the epoch to 0.
    rst_n = 1'b1;
    #1;
    rst_n = 1'b0;
    exp_id = 3'd0;
    for (int i = 0; i < 8; i++) begin
      exp_id = exp_id + 3'd1;
      drive(1'b1, 1'b0, 3'd0);
      total++;
      if (req_branch_id_nxt !== exp_id) begin
        bad++;
        $display("FAIL wrap_pulse%0d: got nxt=%0d, want nxt=%0d", i, req_branch_id_nxt, exp_id);
      end
      tick();
      drive(1'b0, 1'b0, 3'd0);
    end
    drive(1'b0, 1'b1, 3'd0);
    total++;
    if ({req_branch_id_nxt, branch_ack_vld, stale_ack_vld} !== {3'd0, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL wrap_ack0: got nxt=%0d ack=%0b stale=%0b, want nxt=0 ack=1 stale=0",
               req_branch_id_nxt, branch_ack_vld, stale_ack_vld);
    end
    drive(1'b0, 1'b1, 3'd7);
    total++;
    if ({branch_ack_vld, stale_ack_vld} !== 2'b01) begin
      bad++;
      $display("FAIL wrap_ack7: got ack=%0b stale=%0b, want ack=0 stale=1",
               branch_ack_vld, stale_ack_vld);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    // Move the epoch from 0 to 3.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 3'd0);
      tick();
    end
    drive(1'b0, 1'b1, 3'd3);
    total++;
    if ({req_branch_id_nxt, branch_ack_vld} !== {3'd3, 1'b1}) begin
      bad++;
      $display("FAIL b2b_start: got nxt=%0d ack=%0b, want nxt=3 ack=1",
               req_branch_id_nxt, branch_ack_vld);
    end
    drive(1'b1, 1'b1, 3'd3);
    total++;
    if ({req_branch_id_nxt, branch_ack_vld, stale_ack_vld} !== {3'd4, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL b2b_c1_id3: got nxt=%0d ack=%0b stale=%0b, want nxt=4 ack=0 stale=1",
               req_branch_id_nxt, branch_ack_vld, stale_ack_vld);
    end
    tick();
    drive(1'b1, 1'b1, 3'd4);
    total++;
    if ({req_branch_id_nxt, branch_ack_vld, stale_ack_vld} !== {3'd5, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL b2b_c2_id4: got nxt=%0d ack=%0b stale=%0b, want nxt=5 ack=0 stale=1",
               req_branch_id_nxt, branch_ack_vld, stale_ack_vld);
    end
    tick();
    drive(1'b0, 1'b1, 3'd5);
    total++;
    if ({req_branch_id_nxt, branch_ack_vld, stale_ack_vld} !== {3'd5, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL b2b_after_id5: got nxt=%0d ack=%0b stale=%0b, want nxt=5 ack=1 stale=0",
               req_branch_id_nxt, branch_ack_vld, stale_ack_vld);
    end
    drive(1'b0, 1'b1, 3'd3);
    total++;
    if ({branch_ack_vld, stale_ack_vld} !== 2'b01) begin
      bad++;
      $display("FAIL b2b_after_id3: got ack=%0b stale=%0b, want ack=0 stale=1",
               branch_ack_vld, stale_ack_vld);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    // Epoch is 5. One more cancel takes it to 6.
    drive(1'b1, 1'b0, 3'd0);
    tick();
    drive(1'b0, 1'b1, 3'd6);
    total++;
    if ({req_branch_id_nxt, branch_ack_vld} !== {3'd6, 1'b1}) begin
      bad++;
      $display("FAIL mid_pre: got nxt=%0d ack=%0b, want nxt=6 ack=1",
               req_branch_id_nxt, branch_ack_vld);
    end
    // Assert reset mid-cycle, with no clock edge.
    rst_n = 1'b1;
    #1;
    total++;
    if ({req_branch_id_nxt, branch_ack_vld, stale_ack_vld} !== {3'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL mid_async: got nxt=%0d ack=%0b stale=%0b, want nxt=0 ack=0 stale=0",
               req_branch_id_nxt, branch_ack_vld, stale_ack_vld);
    end
    tick();
    drive(1'b0, 1'b1, 3'd0);
    total++;
    if ({req_branch_id_nxt, branch_ack_vld, stale_ack_vld} !== {3'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL mid_held: got nxt=%0d ack=%0b stale=%0b, want nxt=0 ack=0 stale=0",
               req_branch_id_nxt, branch_ack_vld, stale_ack_vld);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({req_branch_id_nxt, branch_ack_vld, stale_ack_vld} !== {3'd0, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL mid_release: got nxt=%0d ack=%0b stale=%0b, want nxt=0 ack=1 stale=0",
               req_branch_id_nxt, branch_ack_vld, stale_ack_vld);
    end
    tick();
  endtask

  task automatic test_no_ack();
    // Epoch is 0 here.
    for (int i = 0; i < 4; i++) begin
      logic       c;
      logic [2:0] id;
      logic [2:0] exp_id;
      c      = (i % 2) == 1;
      id     = 3'(i * 3);
      exp_id = c ? 3'(i / 2 + 1) : 3'(i / 2);
      drive(c, 1'b0, id);
      total++;
      if ({req_branch_id_nxt, branch_ack_vld, stale_ack_vld} !== {exp_id, 1'b0, 1'b0}) begin
        bad++;
        $display("FAIL noack_%0d: got nxt=%0d ack=%0b stale=%0b, want nxt=%0d ack=0 stale=0",
                 i, req_branch_id_nxt, branch_ack_vld, stale_ack_vld, exp_id);
      end
      tick();
    end
  endtask

  initial begin
    total             = 0;
    bad               = 0;
    rst_n             = 1'b1;
    cancel_edge_en    = 1'b0;
    mem_ack_vld       = 1'b0;
    mem_ack_branch_id = 3'd0;
    test_reset();
    test_single_cancel();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    test_no_ack();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_ldq_branch_filter
